// File: rtl/bias_add_stage_pkg.sv
// Layer-wide constants shared by the bias-select mux and the bias add stage.
package bias_add_stage_pkg;
  localparam int DATA_W   = 18;
  localparam int N_LANES  = 16;
  localparam int N_GROUPS = 36;
  localparam int GRP_W    = 6;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic logic [DATA_W-1:0] lane(input logic [N_LANES*DATA_W-1:0] bus, input int i);
    return bus[i*DATA_W +: DATA_W];
  endfunction
endpackage

// File: rtl/bias_add_stage_lane_sat.sv
// Per-lane datapath: widening add for S1, saturate + optional ReLU for S2.
module bias_lane_sat
  import bias_add_stage_pkg::*;
#(
  parameter int RELU_EN = 1
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] bias,
  output logic [DATA_W:0]   sum,
  input  logic [DATA_W:0]   sum_q,
  output logic [DATA_W-1:0] res
);
  logic [DATA_W-1:0] sat;

  assign sum = {acc[DATA_W-1], acc} + {bias[DATA_W-1], bias};

  // overflow shows up as the two top bits of the widened sum disagreeing
  always_comb begin
    if (sum_q[DATA_W] != sum_q[DATA_W-1])
      sat = sum_q[DATA_W] ? SAT_MIN : SAT_MAX;
    else
      sat = sum_q[DATA_W-1:0];
    res = ((RELU_EN != 0) && sat[DATA_W-1]) ? '0 : sat;
  end
endmodule

// File: rtl/bias_add_stage.sv
// Bias add stage: two-register pipeline adding per-group bias to adder-tree sums,
// owning the output-channel-group counter that selects the bias block.
module bias_add_stage
  import bias_add_stage_pkg::*;
#(
  parameter int N_adder_tree = N_LANES,
  parameter int RELU_EN      = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_adder_tree*DATA_W-1:0] in_data,
  input  logic [N_adder_tree*DATA_W-1:0] bias_q,
  output logic [GRP_W-1:0]               grp_idx,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_adder_tree*DATA_W-1:0] out_data,
  output logic                           out_last
);
  localparam int STAGES = 2;

  logic [N_adder_tree-1:0][DATA_W-1:0] acc_l, bias_l, res_l;
  logic [N_adder_tree-1:0][DATA_W:0]   sum_l, sum_q;
  logic [STAGES:1]                     vld_pipe;
  logic                                last_q;
  logic                                s1_ld, s2_ld, acc;

  assign acc_l  = in_data;
  assign bias_l = bias_q;

  assign s2_ld     = !vld_pipe[2] | out_ready;
  assign s1_ld     = !vld_pipe[1] | s2_ld;
  assign in_ready  = rst | s1_ld;
  assign acc       = in_valid & in_ready & !rst;
  assign out_valid = vld_pipe[2];

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    bias_lane_sat #(.RELU_EN(RELU_EN)) u_lane (
      .acc  (acc_l[i]),
      .bias (bias_l[i]),
      .sum  (sum_l[i]),
      .sum_q(sum_q[i]),
      .res  (res_l[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      last_q   <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      grp_idx  <= '0;
    end else begin
      if (s1_ld) begin
        vld_pipe[1] <= acc;
        last_q      <= acc && (grp_idx == GRP_W'(N_GROUPS-1));
        if (acc) sum_q <= sum_l;
      end
      // S2 only refreshes data on a real transfer so held outputs stay put
      if (s2_ld) begin
        vld_pipe[2] <= vld_pipe[1];
        out_last    <= last_q & vld_pipe[1];
        if (vld_pipe[1]) out_data <= res_l;
      end
      if (acc) grp_idx <= (grp_idx == GRP_W'(N_GROUPS-1)) ? '0 : grp_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_bias_add_stage.sv
// Bench for bias_add_stage: ReLU and non-ReLU instances share stimulus and are
// each checked every cycle against a queue-based reference model.
module tb_bias_add_stage;
  import bias_add_stage_pkg::*;

  localparam int N   = N_LANES;
  localparam int BUS = N*DATA_W;
  localparam int HI  = 2**(DATA_W-1) - 1;
  localparam int LO  = -(2**(DATA_W-1));

  typedef struct {
    logic [BUS-1:0] data;
    bit             last;
    int             cyc;
  } exp_t;

  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [BUS-1:0] in_data = '0;
  logic [1:0] in_rdy, out_vld, out_lst;
  logic [BUS-1:0] odat [2];
  logic [BUS-1:0] bq [2];
  logic [GRP_W-1:0] grp [2];
  logic [BUS-1:0] bias_mem [N_GROUPS];
  int total = 0, bad = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb
    for (int k = 0; k < 2; k++)
      bq[k] = (int'(grp[k]) < N_GROUPS) ? bias_mem[int'(grp[k])] : '0;

  bias_add_stage #(.N_adder_tree(N), .RELU_EN(0)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]), .in_data(in_data),
    .bias_q(bq[0]), .grp_idx(grp[0]), .out_valid(out_vld[0]), .out_ready(out_ready),
    .out_data(odat[0]), .out_last(out_lst[0]));

  bias_add_stage #(.N_adder_tree(N), .RELU_EN(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]), .in_data(in_data),
    .bias_q(bq[1]), .grp_idx(grp[1]), .out_valid(out_vld[1]), .out_ready(out_ready),
    .out_data(odat[1]), .out_last(out_lst[1]));

  task automatic chk(string nm, logic [BUS-1:0] got, logic [BUS-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_lane(logic [DATA_W-1:0] a, logic [DATA_W-1:0] b, bit relu);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > HI) s = HI;
    if (s < LO) s = LO;
    if (relu && s < 0) s = 0;
    return DATA_W'(s);
  endfunction

  function automatic logic [BUS-1:0] ref_bus(logic [BUS-1:0] a, logic [BUS-1:0] b, bit relu);
    logic [BUS-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*DATA_W +: DATA_W] = ref_lane(lane(a, i), lane(b, i), relu);
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_lane();
    int v;
    case ($urandom_range(0, 3))
      0:       v = HI - int'($urandom_range(0, 400));
      1:       v = LO + int'($urandom_range(0, 400));
      default: v = int'($urandom_range(0, 2**DATA_W - 1));
    endcase
    return DATA_W'(v);
  endfunction

  function automatic logic [BUS-1:0] rnd_bus();
    logic [BUS-1:0] r;
    for (int i = 0; i < N; i++) r[i*DATA_W +: DATA_W] = rnd_lane();
    return r;
  endfunction

  // k=0 is the pass-through instance, k=1 the ReLU instance
  for (genvar k = 0; k < 2; k++) begin : mon
    exp_t q[$];
    exp_t olog[$];
    int g = 0;
    int nacc = 0;
    bit hold = 0;
    logic [BUS-1:0] prev;
    bit prevl;

    always @(negedge clk) begin
      if (rst) begin
        chk($sformatf("rst_in_ready%0d", k), in_rdy[k], 1);
        q.delete();
        olog.delete();
        g = 0;
        hold = 0;
      end else begin
        bit ev;
        exp_t e;
        ev = (q.size() > 0) && (cyc >= q[0].cyc + 2);
        chk($sformatf("out_valid%0d", k), out_vld[k], ev);
        chk($sformatf("in_ready%0d", k), in_rdy[k], (q.size() < 2) || out_ready);
        chk($sformatf("grp_idx%0d", k), grp[k], g);
        if (out_vld[k] && q.size() > 0) begin
          chk($sformatf("out_data%0d", k), odat[k], q[0].data);
          chk($sformatf("out_last%0d", k), out_lst[k], q[0].last);
        end
        if (hold && out_vld[k]) begin
          chk($sformatf("hold_data%0d", k), odat[k], prev);
          chk($sformatf("hold_last%0d", k), out_lst[k], prevl);
        end
        hold  = out_vld[k] && !out_ready;
        prev  = odat[k];
        prevl = out_lst[k];
        if (out_vld[k] && out_ready && q.size() > 0) begin
          e = q.pop_front();
          e.data = odat[k];
          e.last = out_lst[k];
          e.cyc  = cyc;
          olog.push_back(e);
        end
        if (in_valid && in_rdy[k]) begin
          e.data = ref_bus(in_data, bias_mem[g], k == 1);
          e.last = (g == N_GROUPS - 1);
          e.cyc  = cyc;
          q.push_back(e);
          g = (g == N_GROUPS - 1) ? 0 : g + 1;
          nacc++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0, nl, pos, start, n;
    bit saw_nr;

    for (int i = 0; i < N_GROUPS; i++) bias_mem[i] = rnd_bus();
    bias_mem[0][0*DATA_W +: DATA_W] = 18'd963;
    bias_mem[0][2*DATA_W +: DATA_W] = 18'h3E474;   // -7052
    bias_mem[1][0*DATA_W +: DATA_W] = 18'd200;
    bias_mem[2][0*DATA_W +: DATA_W] = 18'h3FE0C;   // -500

    rst = 1;
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_valid%0d", k), out_vld[k], 0);
      chk($sformatf("reset_last%0d", k), out_lst[k], 0);
      chk($sformatf("reset_data%0d", k), odat[k], 0);
      chk($sformatf("reset_grp%0d", k), grp[k], 0);
    end
    rst = 0;

    // directed: basic add, positive and negative saturation, groups 0..2
    in_data = '0;
    in_data[0 +: DATA_W] = 18'd1000;
    in_valid = 1;
    step();
    in_data[0 +: DATA_W] = 18'd131000;
    step();
    in_data[0 +: DATA_W] = 18'h20048;   // -131000
    step();
    in_valid = 0;
    repeat (5) step();
    chk("dir_count1", mon[1].olog.size(), 3);
    chk("dir_count0", mon[0].olog.size(), 3);
    if (mon[1].olog.size() >= 3 && mon[0].olog.size() >= 3) begin
      chk("basic_l0", lane(mon[1].olog[0].data, 0), 18'd1963);
      chk("basic_l2_relu", lane(mon[1].olog[0].data, 2), 0);
      chk("basic_l2_norelu", lane(mon[0].olog[0].data, 2), 18'h3E474);
      chk("pos_sat", lane(mon[1].olog[1].data, 0), 18'd131071);
      chk("neg_sat", lane(mon[0].olog[2].data, 0), 18'h20000);
      chk("neg_sat_relu", lane(mon[1].olog[2].data, 0), 0);
      chk("back_to_back", mon[1].olog[1].cyc - mon[1].olog[0].cyc, 1);
    end

    // group wrap: 37 back-to-back accepts
    rst = 1;
    repeat (2) step();
    rst = 0;
    in_valid = 1;
    c0 = cyc;
    repeat (37) begin
      in_data = rnd_bus();
      step();
    end
    in_valid = 0;
    chk("wrap_grp", grp[1], 1);
    repeat (5) step();
    chk("wrap_count", mon[1].olog.size(), 37);
    nl = 0;
    pos = -1;
    foreach (mon[1].olog[i]) if (mon[1].olog[i].last) begin nl++; pos = i; end
    chk("wrap_nlast", nl, 1);
    chk("wrap_lastpos", pos, 35);
    if (mon[1].olog.size() == 37) begin
      chk("wrap_first_cyc", mon[1].olog[0].cyc, c0 + 2);
      chk("wrap_final_cyc", mon[1].olog[36].cyc, c0 + 38);
    end

    // backpressure: stall 5 cycles mid-stream
    out_ready = 1;
    in_valid = 1;
    repeat (4) begin
      in_data = rnd_bus();
      step();
    end
    out_ready = 0;
    saw_nr = 0;
    repeat (5) begin
      in_data = rnd_bus();
      step();
      if (!in_rdy[1]) saw_nr = 1;
    end
    chk("stall_not_ready", saw_nr, 1);
    chk("stall_grp", grp[1], 5);
    out_ready = 1;
    in_valid = 0;
    repeat (5) step();

    // reset with both stages full at grp 17
    in_valid = 1;
    repeat (12) begin
      in_data = rnd_bus();
      step();
    end
    in_valid = 0;
    out_ready = 0;
    chk("pre_rst_grp", grp[1], 17);
    chk("pre_rst_valid", out_vld[1], 1);
    step();
    rst = 1;
    step();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("mid_rst_valid%0d", k), out_vld[k], 0);
      chk($sformatf("mid_rst_grp%0d", k), grp[k], 0);
    end
    rst = 0;
    out_ready = 1;
    in_data = '0;
    in_data[0 +: DATA_W] = 18'd1000;
    in_valid = 1;
    step();
    in_valid = 0;
    repeat (4) step();
    chk("post_rst_count", mon[1].olog.size(), 1);
    if (mon[1].olog.size() >= 1) begin
      chk("post_rst_l0", lane(mon[1].olog[0].data, 0), 18'd1963);
      chk("post_rst_last", mon[1].olog[0].last, 0);
    end

    // random traffic with random backpressure
    start = mon[1].nacc;
    n = 0;
    while ((mon[1].nacc - start) < 1000 && n < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_data   = rnd_bus();
      step();
      n++;
    end
    chk("rand_accepts", (mon[1].nacc - start) >= 1000, 1);
    in_valid = 0;
    out_ready = 1;
    repeat (6) step();
    chk("drain0", mon[0].q.size(), 0);
    chk("drain1", mon[1].q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
